// File: rtl/aes_seq_ctrl.sv
// Bus-master sequencer that runs one complete aes block operation per start pulse.
// Define AES_SEQ_TIMEOUT_EN to bound each STATUS wait to TIMEOUT_CYCLES polls.
module aes_seq_ctrl #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         encdec,
  input  logic         keylen,
  input  logic         key_reload,
  input  logic [255:0] key_i,
  input  logic [127:0] block_i,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result_o,
  output logic         aes_cs,
  output logic         aes_we,
  output logic [7:0]   aes_addr,
  output logic [31:0]  aes_wdata,
  input  logic [31:0]  aes_rdata
);

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
  localparam logic [7:0] ADDR_KEY0    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_RESULT0 = 8'h30;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CFG, S_WR_KEY, S_INIT, S_SETTLE,
    S_POLL, S_WR_BLK, S_NEXT, S_RD_RES, S_DONE
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '0;

  function automatic bus_t bus_wr(input logic [7:0] a, input logic [31:0] d);
    bus_t b;
    b.cs    = 1'b1;
    b.we    = 1'b1;
    b.addr  = a;
    b.wdata = d;
    return b;
  endfunction

  function automatic bus_t bus_rd(input logic [7:0] a);
    bus_t b;
    b.cs    = 1'b1;
    b.we    = 1'b0;
    b.addr  = a;
    b.wdata = 32'h0;
    return b;
  endfunction

  state_t       state_reg;
  bus_t         bus_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         encdec_reg;
  logic         keylen_reg;
  logic         key_reload_reg;
  logic [255:0] key_reg;
  logic [127:0] block_reg;
  logic         key_valid_reg;
  logic         cached_keylen_reg;
  logic         after_init_reg;
  logic [2:0]   word_cnt_reg;
  logic [3:0]   settle_cnt_reg;
  logic [31:0]  result_words_reg [4];
  logic [31:0]  key_words [8];
  logic [31:0]  block_words [4];

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int POLL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(TIMEOUT_CYCLES - 1);
  logic [POLL_W-1:0] poll_cnt_reg;
  logic              error_reg;
  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  // Word n of the key/block/result sits at the MSB end: word 0 is bits [top -: 32].
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key_words
      assign key_words[gi] = key_reg[255-32*gi -: 32];
    end
    for (gi = 0; gi < 4; gi++) begin : g_blk_words
      assign block_words[gi]             = block_reg[127-32*gi -: 32];
      assign result_o[127-32*gi -: 32]   = result_words_reg[gi];
    end
  endgenerate

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign aes_cs    = bus_reg.cs;
  assign aes_we    = bus_reg.we;
  assign aes_addr  = bus_reg.addr;
  assign aes_wdata = bus_reg.wdata;

  // bus_reg always holds the access belonging to the current state, so every
  // transition loads the first access of the state being entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg         <= S_IDLE;
      bus_reg           <= BUS_IDLE;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      encdec_reg        <= 1'b0;
      keylen_reg        <= 1'b0;
      key_reload_reg    <= 1'b0;
      key_reg           <= '0;
      block_reg         <= '0;
      key_valid_reg     <= 1'b0;
      cached_keylen_reg <= 1'b0;
      after_init_reg    <= 1'b0;
      word_cnt_reg      <= '0;
      settle_cnt_reg    <= '0;
      for (int i = 0; i < 4; i++) result_words_reg[i] <= '0;
`ifdef AES_SEQ_TIMEOUT_EN
      poll_cnt_reg      <= '0;
      error_reg         <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      bus_reg  <= BUS_IDLE;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            encdec_reg     <= encdec;
            keylen_reg     <= keylen;
            key_reload_reg <= key_reload;
            key_reg        <= key_i;
            block_reg      <= block_i;
            busy_reg       <= 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
            error_reg      <= 1'b0;
`endif
            state_reg      <= S_WR_CFG;
            bus_reg        <= bus_wr(ADDR_CONFIG, {30'b0, keylen, encdec});
          end
        end
        S_WR_CFG: begin
          word_cnt_reg <= '0;
          if (key_valid_reg && !key_reload_reg && (keylen_reg == cached_keylen_reg)) begin
            state_reg <= S_WR_BLK;
            bus_reg   <= bus_wr(ADDR_BLOCK0, block_words[0]);
          end else begin
            key_valid_reg <= 1'b0;
            state_reg     <= S_WR_KEY;
            bus_reg       <= bus_wr(ADDR_KEY0, key_words[0]);
          end
        end
        S_WR_KEY: begin
          if (word_cnt_reg == {keylen_reg, 2'b11}) begin
            state_reg <= S_INIT;
            bus_reg   <= bus_wr(ADDR_CTRL, 32'h1);
          end else begin
            word_cnt_reg <= word_cnt_reg + 3'd1;
            bus_reg      <= bus_wr(ADDR_KEY0 + {5'b0, word_cnt_reg + 3'd1},
                                   key_words[word_cnt_reg + 3'd1]);
          end
        end
        S_INIT: begin
          after_init_reg <= 1'b1;
          settle_cnt_reg <= '0;
          state_reg      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg <= S_POLL;
            bus_reg   <= bus_rd(ADDR_STATUS);
`ifdef AES_SEQ_TIMEOUT_EN
            poll_cnt_reg <= '0;
`endif
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 4'd1;
          end
        end
        S_POLL: begin
          if (aes_rdata[0]) begin
            word_cnt_reg <= '0;
            if (after_init_reg) begin
              key_valid_reg     <= 1'b1;
              cached_keylen_reg <= keylen_reg;
              state_reg         <= S_WR_BLK;
              bus_reg           <= bus_wr(ADDR_BLOCK0, block_words[0]);
            end else begin
              state_reg <= S_RD_RES;
              bus_reg   <= bus_rd(ADDR_RESULT0);
            end
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (poll_cnt_reg == POLL_LAST) begin
            // Core never came ready: drop the key cache and finish without a result.
            key_valid_reg <= 1'b0;
            error_reg     <= 1'b1;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= S_DONE;
          end
`endif
          else begin
            bus_reg <= bus_rd(ADDR_STATUS);
`ifdef AES_SEQ_TIMEOUT_EN
            poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
`endif
          end
        end
        S_WR_BLK: begin
          if (word_cnt_reg == 3'd3) begin
            state_reg <= S_NEXT;
            bus_reg   <= bus_wr(ADDR_CTRL, 32'h2);
          end else begin
            word_cnt_reg <= word_cnt_reg + 3'd1;
            bus_reg      <= bus_wr(ADDR_BLOCK0 + {5'b0, word_cnt_reg + 3'd1},
                                   block_words[word_cnt_reg[1:0] + 2'd1]);
          end
        end
        S_NEXT: begin
          after_init_reg <= 1'b0;
          settle_cnt_reg <= '0;
          state_reg      <= S_SETTLE;
        end
        S_RD_RES: begin
          result_words_reg[word_cnt_reg[1:0]] <= aes_rdata;
          if (word_cnt_reg == 3'd3) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_DONE;
          end else begin
            word_cnt_reg <= word_cnt_reg + 3'd1;
            bus_reg      <= bus_rd(ADDR_RESULT0 + {5'b0, word_cnt_reg + 3'd1});
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Scoreboard bench for aes_seq_ctrl with a behavioural aes register-interface stub.
`timescale 1ns/1ps
module tb_aes_seq_ctrl;
  localparam int SETTLE = 2;
  localparam int TMO    = 16;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0, encdec = 1'b0, keylen = 1'b0, key_reload = 1'b0;
  logic [255:0] key_i = '0;
  logic [127:0] block_i = '0;
  logic         busy, done, error;
  logic [127:0] result_o;
  logic         aes_cs, aes_we;
  logic [7:0]   aes_addr;
  logic [31:0]  aes_wdata;
  logic [31:0]  aes_rdata;

  always #5 clk = ~clk;

  aes_seq_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .encdec(encdec), .keylen(keylen),
    .key_reload(key_reload), .key_i(key_i), .block_i(block_i), .busy(busy),
    .done(done), .error(error), .result_o(result_o), .aes_cs(aes_cs),
    .aes_we(aes_we), .aes_addr(aes_addr), .aes_wdata(aes_wdata), .aes_rdata(aes_rdata)
  );

  // Stand-in cipher: known answers for the reference vectors, a keyed mix otherwise.
  function automatic logic [127:0] core_func(input logic [255:0] k, input logic kl,
                                             input logic enc, input logic [127:0] b);
    if (!kl && k[255:128] == K128 && enc && b == PT)     return CT128;
    if (!kl && k[255:128] == K128 && !enc && b == CT128) return PT;
    if (kl && k == K256 && enc && b == PT)               return CT256;
    return {b[63:0], b[127:64]} ^ k[255:128] ^ (kl ? k[127:0] : 128'h0) ^
           (enc ? 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0 : 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
  endfunction

  // ---------------- aes register-interface stub ----------------
  logic [31:0]  key_r [8];
  logic [31:0]  blk_r [4];
  logic         cfg_enc = 1'b0, cfg_kl = 1'b0, exp_kl = 1'b0, ready = 1'b1;
  logic [255:0] exp_key = '0;
  logic [127:0] res_r = '0;
  int           lat = 0;
  bit           stall = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      ready <= 1'b1;
      lat   <= 0;
    end else begin
      if (lat > 0) begin
        lat <= lat - 1;
        if (lat == 1) ready <= 1'b1;
      end
      if (aes_cs && aes_we) begin
        if (aes_addr == 8'h0a) begin
          cfg_enc <= aes_wdata[0];
          cfg_kl  <= aes_wdata[1];
        end else if (aes_addr[7:3] == 5'b00010) begin
          key_r[aes_addr[2:0]] <= aes_wdata;
        end else if (aes_addr[7:2] == 6'b001000) begin
          blk_r[aes_addr[1:0]] <= aes_wdata;
        end else if (aes_addr == 8'h08) begin
          if (aes_wdata[0]) begin
            exp_key <= {key_r[0], key_r[1], key_r[2], key_r[3],
                        cfg_kl ? {key_r[4], key_r[5], key_r[6], key_r[7]} : 128'h0};
            exp_kl  <= cfg_kl;
          end
          if (aes_wdata[1])
            res_r <= core_func(exp_key, exp_kl, cfg_enc, {blk_r[0], blk_r[1], blk_r[2], blk_r[3]});
          ready <= 1'b0;
          lat   <= $urandom_range(1, 6);
        end
      end
    end
  end

  always_comb begin
    aes_rdata = '0;
    if (aes_cs && !aes_we) begin
      if (aes_addr == 8'h09)
        aes_rdata = {31'b0, ready & ~stall};
      else if (aes_addr[7:2] == 6'b001100)
        aes_rdata = res_r[32*(3-int'(aes_addr[1:0])) +: 32];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] res;
    int           writes;
    logic         err;
    int           polls;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic finish_tb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  int   wr_cnt = 0, st_cnt = 0, gap = 0, op_no = 0;
  bit   gap_on = 1'b0, prev_done = 1'b0;
  exp_t got_e;

  always @(negedge clk) begin
    if (!rstn) begin
      wr_cnt = 0; st_cnt = 0; gap_on = 1'b0; prev_done = 1'b0;
    end else begin
      if (aes_cs && aes_we) wr_cnt++;
      if (aes_cs && !aes_we && aes_addr == 8'h09) st_cnt++;
      if (gap_on && aes_cs) begin
        check("settle_gap", 128'(gap), 128'(SETTLE));
        check("first_poll_addr", 128'(aes_addr), 128'h09);
        gap_on = 1'b0;
      end else if (gap_on) begin
        gap++;
      end
      if (aes_cs && aes_we && aes_addr == 8'h08) begin
        gap_on = 1'b1;
        gap    = 0;
      end
      if (done) begin
        check("done_width", 128'(prev_done), 128'h0);
        check("busy_at_done", 128'(busy), 128'h0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no pending operation");
        end else begin
          got_e = exp_q.pop_front();
          op_no++;
          $display("op %0d: result %h writes %0d polls %0d error %0d", op_no, result_o, wr_cnt, st_cnt, error);
          check("result", result_o, got_e.res);
          check("write_count", 128'(wr_cnt), 128'(got_e.writes));
          check("error_flag", 128'(error), 128'(got_e.err));
          if (got_e.polls >= 0) check("poll_count", 128'(st_cnt), 128'(got_e.polls));
        end
        wr_cnt = 0;
        st_cnt = 0;
      end
      prev_done = done;
    end
  end

  // ---------------- reference model of the sequencer's key cache ----------------
  bit           model_kv = 1'b0;
  logic         model_kl = 1'b0;
  logic [255:0] model_key = '0;
  logic [127:0] last_res = '0;

  task automatic do_op(input logic e, input logic kl, input logic rl, input logic [255:0] k,
                       input logic [127:0] b, input bit poke, input bit tmo);
    exp_t x;
    bit   cached, got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (!busy && !done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      $display("FAIL idle_wait: got busy=%0d, expected 0 within 200 cycles", busy);
      n_cmp++; n_bad++;
      finish_tb();
    end
    cached = model_kv && !rl && (kl == model_kl);
    if (!cached) model_key = kl ? k : {k[255:128], 128'h0};
    if (tmo) begin
      x.res    = last_res;
      x.writes = cached ? 6 : (kl ? 10 : 6);
      x.err    = 1'b1;
      x.polls  = TMO;
      model_kv = 1'b0;
    end else begin
      x.res    = core_func(model_key, kl, e, b);
      x.writes = cached ? 6 : (kl ? 15 : 11);
      x.err    = 1'b0;
      x.polls  = -1;
      model_kv = 1'b1;
      model_kl = kl;
      last_res = x.res;
    end
    encdec = e; keylen = kl; key_reload = rl; key_i = k; block_i = b;
    start = 1'b1;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the sequencer must work from its latched copy.
    key_i   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    block_i = {$urandom, $urandom, $urandom, $urandom};
    encdec  = ~e; keylen = ~kl; key_reload = ~rl;
    check("busy_after_start", 128'(busy), 128'h1);
    check("error_after_start", 128'(error), 128'h0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL done_wait: got done=0, expected a done pulse within 3000 cycles");
      n_cmp++; n_bad++;
      finish_tb();
    end
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [255:0] key_pool [2];

  initial begin
    logic rkl, rrl, re;
    bit   got;
    // Reset held for 3 cycles, then 10 quiet cycles.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 128'({busy, done, error, aes_cs, aes_we, aes_addr, aes_wdata}), 128'h0);
    check("reset_result", result_o, 128'h0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", 128'({busy, done, error, aes_cs, aes_we, aes_addr, aes_wdata}), 128'h0);
    end

    // Reference vectors: AES-128 encrypt, cached decrypt, AES-256 encrypt.
    do_op(1'b1, 1'b0, 1'b0, {K128, 128'h0}, PT, 1'b0, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, {K128, 128'h0}, CT128, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 1'b0, K256, PT, 1'b0, 1'b0);

    // Start, stray start 5 cycles later, then reset during the first STATUS poll.
    encdec = 1'b1; keylen = 1'b0; key_reload = 1'b0; key_i = {K128, 128'h0}; block_i = PT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (aes_cs && !aes_we && aes_addr == 8'h09) got = 1'b1;
    end
    check("reached_poll", 128'(got), 128'h1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_cs", 128'(aes_cs), 128'h0);
    check("abort_busy", 128'(busy), 128'h0);
    rstn = 1'b1;
    model_kv = 1'b0;
    last_res = '0;
    do_op(1'b1, 1'b0, 1'b0, {K128, 128'h0}, PT, 1'b0, 1'b0);

    // Randomised traffic over a small key pool so the cache both hits and misses.
    key_pool[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_pool[1] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rkl = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) rkl = ~rkl;
      rrl = ($urandom_range(0, 5) == 0);
      re  = 1'($urandom_range(0, 1));
      do_op(re, rkl, rrl, key_pool[$urandom_range(0, 1)],
            {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'b0);
    end

`ifdef AES_SEQ_TIMEOUT_EN
    // Core that never reports ready: timeout after TMO polls, error held until next start.
    stall = 1'b1;
    do_op(1'b1, 1'b0, 1'b1, {K128, 128'h0}, PT, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("error_held", 128'(error), 128'h1);
    stall = 1'b0;
    do_op(1'b1, 1'b0, 1'b0, {K128, 128'h0}, PT, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'h0);
    finish_tb();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
